rnd_share_arbiter: RTL and testbench
====================================

// Module: rnd_share_arbiter
// PURPOSE
//  Shares the single 9-bit pseudo-random source among NREQ game-logic requesters
//  (spawners, movers, etc.).
//  - Round-robin arbitration picks one requester at a time.
//  - The winner waits for a fresh sample and receives it with a one-cycle grant pulse.
//  - Each fresh sample is delivered to at most one requester, so no two clients share a value.
//  - Sits between the LFSR output and the game FSMs.
// PARAMETERS
//  NREQ     4   number of requesters (2..8)
//  W        9   sample width; must match the random source width
//  MAX_TRY  7   consecutive rejections before fallback (used only with RND_REJECT_EN)
// PORTS
//  clk          in   1       system clock
//  Reset        in   1       reset, asynchronous, active-high
//  req          in   NREQ    level request per client; held until its gnt bit pulses
//  req_bound    in   NREQ*W  per-client exclusive upper bound; client i uses [i*W +: W]
//  rnd_in       in   W       current random-source value
//  rnd_fresh    in   1       1-cycle strobe: rnd_in holds a new, unused sample
//  gnt          out  NREQ    one-hot 1-cycle pulse; rnd_out is valid in that cycle
//  rnd_out      out  W       delivered sample; held until the next delivery
//  busy         out  1       1 while in WAIT or DELIVER
//  rnd_fallback out  1       1-cycle pulse with gnt when a fallback value is delivered
// BEHAVIOUR
//  Reset (async): state=IDLE, gnt=0, rnd_out=0, busy=0, rnd_fallback=0,
//   owner=0, try_cnt=0, rr_ptr=NREQ-1 (client 0 wins the first arbitration).
//  FSM states: IDLE, WAIT, DELIVER.
//  IDLE:
//   - If |req: owner = first set bit scanning rr_ptr+1, rr_ptr+2, ... mod NREQ;
//     clear try_cnt; go to WAIT.
//   - rnd_fresh while in IDLE is discarded. This includes the cycle in which a
//     winner is chosen.
//  WAIT:
//   - If req[owner] deasserts: abort to IDLE with no gnt; rr_ptr unchanged.
//     Abort has priority over a coincident rnd_fresh.
//   - Else on rnd_fresh:
//     - If the sample is accepted: rnd_out <= rnd_in; go to DELIVER.
//     - If the sample is rejected: try_cnt++; stay in WAIT (with RND_REJECT_EN only).
//  DELIVER (exactly 1 cycle):
//   - gnt[owner]=1; rr_ptr <= owner; go to IDLE.
//   - Another request may be arbitrated in the very next IDLE cycle.
//  Latency:
//   - req rises in cycle 0 with FSM idle -> WAIT from cycle 1.
//   - First rnd_fresh seen in WAIT at cycle k -> gnt high in cycle k+1.
//   - Minimum req-to-gnt latency is 2 cycles.
//  Sample reuse: a sample is consumed by the first WAIT cycle that sees rnd_fresh;
//   it is never delivered twice.
//  Round robin: a continuously requesting client waits at most NREQ-1 deliveries.
//  Output timing: gnt, rnd_fallback and busy are registered (no combinational path
//   from req); gnt is never multi-hot.
//  Boundary conditions:
//   - req=0 or a single requester: same behaviour, no idle gaps beyond the FSM.
//   - Reset asserted mid-WAIT/DELIVER: all state is cleared; any pending gnt is lost.
//   - req bits for non-owners changing during WAIT have no effect until the next IDLE.
// CONFIGURATION
//  Macro: RND_REJECT_EN
//  Defined (rejection sampling):
//   - b = req_bound[owner]; b==0 means unbounded.
//   - A sample is accepted iff b==0 or rnd_in < b; otherwise it is rejected.
//   - When try_cnt reaches MAX_TRY, the next rejected sample instead delivers
//     rnd_out=0 with rnd_fallback=1 alongside gnt.
//  Not defined:
//   - req_bound is ignored; every rnd_fresh seen in WAIT is accepted raw.
//   - rnd_fallback is tied to 0; try_cnt logic is omitted.
// TESTING
//  T1: Reset, req=4'b0001, rnd_fresh pulse with rnd_in=9'h0AB two cycles later
//      -> gnt=4'b0001 next cycle, rnd_out=9'h0AB, busy low afterwards.
//  T2: req=4'b1111 held; 8 fresh samples 1..8
//      -> grant order 0,1,2,3,0,1,2,3; values 1..8 in order; no sample delivered twice.
//  T3: rnd_fresh in the same cycle req rises from IDLE -> discarded.
//      Next fresh value 9'h055 -> delivered.
//  T4: req[2] dropped while its owner waits in WAIT, with a coincident rnd_fresh
//      -> no gnt; rr_ptr unchanged; the sample is not delivered to anyone.
//  T5 (RND_REJECT_EN): bound=9'd20, samples 300, 25, 7 -> single gnt with rnd_out=7.
//      Same bound with 8 samples >=20 -> gnt with rnd_out=0 and rnd_fallback=1.
//  T6: assert Reset during DELIVER -> gnt=0 immediately; outputs at reset values;
//      client 0 wins the next arbitration.

Source files
------------

// File: rtl/rnd_share_arbiter.sv
// rnd_share_arbiter
//   Shares one W-bit pseudo-random source among NREQ requesters. A round-robin
//   arbiter picks one requester, which then waits for the next fresh sample and
//   receives it with a one-cycle gnt pulse. Every fresh sample goes to at most
//   one requester, so no two clients ever see the same value.
//
//   Optional feature (macro RND_REJECT_EN): rejection sampling against a
//   per-client exclusive upper bound, with a zero-valued fallback delivery after
//   MAX_TRY consecutive rejections.
//
// Ports
//   clk          in   1       system clock
//   Reset        in   1       asynchronous, active-high reset
//   req          in   NREQ    level request per client, held until its gnt pulses
//   req_bound    in   NREQ*W  per-client exclusive bound, client i at [i*W +: W]
//   rnd_in       in   W       current random-source value
//   rnd_fresh    in   1       strobe: rnd_in holds a new, unused sample
//   gnt          out  NREQ    one-hot 1-cycle grant; rnd_out valid in that cycle
//   rnd_out      out  W       delivered sample, held until the next delivery
//   busy         out  1       high while in WAIT or DELIVER
//   rnd_fallback out  1       pulses with gnt when a fallback value is delivered
module rnd_share_arbiter #(
    parameter int NREQ    = 4,
    parameter int W       = 9,
    parameter int MAX_TRY = 7
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] req_bound,
    input  logic [W-1:0]      rnd_in,
    input  logic              rnd_fresh,
    output logic [NREQ-1:0]   gnt,
    output logic [W-1:0]      rnd_out,
    output logic              busy,
    output logic              rnd_fallback
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, DELIVER} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   owner, rr_ptr, winner;
    logic            accept, at_max, take;
    logic [NREQ-1:0] gnt_nxt;
    logic            busy_nxt, fallback_nxt;

    // First set request bit scanning upward from the slot after the last winner.
    function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [IW-1:0]   p);
        logic [IW-1:0] sel;
        logic          found;
        int            idx;
        sel   = p;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(p) + k) % NREQ;
            if (!found && r[IW'(idx)]) begin
                sel   = IW'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign winner = rr_pick(req, rr_ptr);

`ifdef RND_REJECT_EN
    localparam int TW = $clog2(MAX_TRY + 1);

    logic [TW-1:0] try_cnt;
    logic [W-1:0]  bound;

    // A zero bound means the client accepts any sample.
    assign bound  = req_bound[int'(owner)*W +: W];
    assign accept = (bound == '0) || (rnd_in < bound);
    assign at_max = (try_cnt == TW'(MAX_TRY));

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            try_cnt <= '0;
        end else if (state == IDLE && |req) begin
            try_cnt <= '0;
        end else if (state == WAIT && req[owner] && rnd_fresh && !accept && !at_max) begin
            try_cnt <= try_cnt + 1'b1;
        end
    end
`else
    logic unused_cfg;

    assign accept     = 1'b1;
    assign at_max     = 1'b0;
    assign unused_cfg = ^{req_bound, (MAX_TRY != 0)};
`endif

    // A fresh sample is consumed only by a WAIT cycle whose owner still requests;
    // a rejected sample at the retry limit turns into a fallback delivery.
    assign take = (state == WAIT) && req[owner] && rnd_fresh && (accept || at_max);

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req) state_nxt = WAIT;
            WAIT: begin
                if (!req[owner]) state_nxt = IDLE;
                else if (take)   state_nxt = DELIVER;
            end
            DELIVER: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are computed one cycle ahead and registered, so gnt is high exactly
    // during DELIVER with no combinational path from req.
    always_comb begin
        gnt_nxt      = '0;
        fallback_nxt = 1'b0;
        busy_nxt     = (state_nxt != IDLE);
        if (take) begin
            gnt_nxt[owner] = 1'b1;
            fallback_nxt   = !accept;
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            gnt          <= '0;
            busy         <= 1'b0;
            rnd_fallback <= 1'b0;
        end else begin
            gnt          <= gnt_nxt;
            busy         <= busy_nxt;
            rnd_fallback <= fallback_nxt;
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            owner   <= '0;
            rr_ptr  <= IW'(NREQ - 1);
            rnd_out <= '0;
        end else begin
            if (state == IDLE && |req) owner <= winner;
            if (state == DELIVER)      rr_ptr <= owner;
            if (take)                  rnd_out <= accept ? rnd_in : '0;
        end
    end

endmodule

// File: tb/tb_rnd_share_arbiter.sv
module tb_rnd_share_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 9;

    logic              clk;
    logic              Reset;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] req_bound;
    logic [W-1:0]      rnd_in;
    logic              rnd_fresh;
    logic [NREQ-1:0]   gnt;
    logic [W-1:0]      rnd_out;
    logic              busy;
    logic              rnd_fallback;

    rnd_share_arbiter #(.NREQ(NREQ), .W(W), .MAX_TRY(7)) dut (
        .clk          (clk),
        .Reset        (Reset),
        .req          (req),
        .req_bound    (req_bound),
        .rnd_in       (rnd_in),
        .rnd_fresh    (rnd_fresh),
        .gnt          (gnt),
        .rnd_out      (rnd_out),
        .busy         (busy),
        .rnd_fallback (rnd_fallback)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       fresh;
        logic [8:0] rin;
        logic [3:0] egnt;
        logic [8:0] eout;
        logic       ebusy;
    } vec_t;

    vec_t vecs[64];
    int   nvec   = 0;
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic add(input logic rst, input logic [3:0] rq, input logic fr,
                       input logic [8:0] rin, input logic [3:0] eg,
                       input logic [8:0] eo, input logic eb);
        vecs[nvec] = '{rst, rq, fr, rin, eg, eo, eb};
        nvec++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] eg, input logic [8:0] eo,
                           input logic eb, input logic ef);
        chk({tag, ".gnt"},  32'(gnt), 32'(eg));
        chk({tag, ".rnd_out"}, 32'(rnd_out), 32'(eo));
        chk({tag, ".busy"}, 32'(busy), 32'(eb));
        chk({tag, ".fallback"}, 32'(rnd_fallback), 32'(ef));
    endtask

    initial begin
        logic [3:0] g;
        Reset     = 1'b1;
        req       = '0;
        req_bound = '0;
        rnd_in    = '0;
        rnd_fresh = 1'b0;
        tick();
        tick();
        chk_out("reset", 4'b0000, 9'h000, 1'b0, 1'b0);
        Reset = 1'b0;

        // T1: single requester, sample two cycles after req
        add(0, 4'b0001, 0, 9'h000, 4'b0000, 9'h000, 1);
        add(0, 4'b0001, 0, 9'h000, 4'b0000, 9'h000, 1);
        add(0, 4'b0001, 1, 9'h0AB, 4'b0001, 9'h0AB, 1);
        add(0, 4'b0000, 0, 9'h000, 4'b0000, 9'h0AB, 0);
        add(0, 4'b0000, 0, 9'h000, 4'b0000, 9'h0AB, 0);
        // T2: fresh reset, all four requesting, samples 1..8
        add(1, 4'b0000, 0, 9'h000, 4'b0000, 9'h000, 0);
        for (int i = 0; i < 8; i++) begin
            g = 4'b0001 << (i % 4);
            add(0, 4'b1111, 0, 9'h000, 4'b0000, (i == 0) ? 9'd0 : 9'(i), 1);
            add(0, 4'b1111, 1, 9'(i + 1), g, 9'(i + 1), 1);
            add(0, 4'b1111, 0, 9'h000, 4'b0000, 9'(i + 1), 0);
        end
        // T3: fresh coincident with req rising from IDLE is discarded
        add(0, 4'b0100, 1, 9'h1FF, 4'b0000, 9'd8, 1);
        add(0, 4'b0100, 0, 9'h000, 4'b0000, 9'd8, 1);
        add(0, 4'b0100, 1, 9'h055, 4'b0100, 9'h055, 1);
        add(0, 4'b0000, 0, 9'h000, 4'b0000, 9'h055, 0);

        for (int i = 0; i < nvec; i++) begin
            Reset     = vecs[i].rst;
            req       = vecs[i].req;
            rnd_fresh = vecs[i].fresh;
            rnd_in    = vecs[i].rin;
            tick();
            chk_out($sformatf("vec%0d", i), vecs[i].egnt, vecs[i].eout, vecs[i].ebusy, 1'b0);
        end
        Reset = 1'b0;

        // T4: owner (client 2) drops req with a coincident fresh sample
        req = 4'b0100; rnd_fresh = 1'b0;
        tick();
        chk("t4.wait_busy", 32'(busy), 32'd1);
        req = 4'b0000; rnd_fresh = 1'b1; rnd_in = 9'h123;
        tick();
        chk_out("t4.abort", 4'b0000, 9'h055, 1'b0, 1'b0);
        req = 4'b1111; rnd_fresh = 1'b0;
        tick();
        rnd_fresh = 1'b1; rnd_in = 9'h0AA;
        tick();
        chk_out("t4.next_rr", 4'b1000, 9'h0AA, 1'b1, 1'b0);
        req = 4'b0000; rnd_fresh = 1'b0;
        tick();
        chk("t4.idle", 32'(busy), 32'd0);

        // T6: asynchronous reset during DELIVER
        req = 4'b0010;
        tick();
        rnd_fresh = 1'b1; rnd_in = 9'h077;
        tick();
        chk("t6.gnt_before", 32'(gnt), 32'b0010);
        rnd_fresh = 1'b0;
        #2 Reset = 1'b1;
        #1;
        chk_out("t6.async", 4'b0000, 9'h000, 1'b0, 1'b0);
        req = 4'b0000;
        @(posedge clk);
        #1 Reset = 1'b0;
        req = 4'b1111;
        tick();
        rnd_fresh = 1'b1; rnd_in = 9'h0C3;
        tick();
        chk_out("t6.first_win", 4'b0001, 9'h0C3, 1'b1, 1'b0);
        req = 4'b0000; rnd_fresh = 1'b0;
        tick();

`ifdef RND_REJECT_EN
        // T5: bound 20 on client 0
        req_bound = 36'd20;
        req = 4'b0001;
        tick();
        rnd_fresh = 1'b1; rnd_in = 9'd300;
        tick();
        chk_out("t5.rej300", 4'b0000, 9'h0C3, 1'b1, 1'b0);
        rnd_in = 9'd25;
        tick();
        chk_out("t5.rej25", 4'b0000, 9'h0C3, 1'b1, 1'b0);
        rnd_in = 9'd7;
        tick();
        chk_out("t5.acc7", 4'b0001, 9'd7, 1'b1, 1'b0);
        req = 4'b0000; rnd_fresh = 1'b0;
        tick();
        req = 4'b0001;
        tick();
        for (int s = 0; s < 8; s++) begin
            rnd_fresh = 1'b1; rnd_in = 9'(20 + s * 30);
            tick();
            if (s < 7) chk($sformatf("t5.rej%0d", s), 32'(gnt), 32'd0);
            else       chk_out("t5.fallback", 4'b0001, 9'd0, 1'b1, 1'b1);
        end
        req = 4'b0000; rnd_fresh = 1'b0;
        tick();
        chk("t5.fb_clear", 32'(rnd_fallback), 32'd0);
`else
        // Without rejection sampling the bound is ignored and samples pass raw.
        req_bound = 36'd20;
        req = 4'b0001;
        tick();
        rnd_fresh = 1'b1; rnd_in = 9'd300;
        tick();
        chk_out("raw.bound_ignored", 4'b0001, 9'd300, 1'b1, 1'b0);
        req = 4'b0000; rnd_fresh = 1'b0;
        tick();
        chk("raw.idle", 32'(busy), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
